// File: rtl/data_cache_pkg.sv
`default_nettype none
// ============================================================================
// Module      : data_cache_pkg
// Description : Shared FSM encoding, line geometry and address-split helpers
//               for the direct-mapped write-through data cache.
// Revision    : 1.0 - initial release
// ============================================================================
package data_cache_pkg;

    localparam int c_WORDS_PER_LINE = 4;
    localparam int c_BYTE_W         = 2;
    localparam int c_OFFSET_W       = 2;
    localparam int c_LINE_LSB       = c_BYTE_W + c_OFFSET_W;
    localparam int c_MAX_INDEX_W    = 6;
    localparam int c_MAX_TAG_W      = 32 - c_LINE_LSB;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic logic [c_OFFSET_W-1:0] addr_offset(input logic [31:0] addr);
        return c_OFFSET_W'(addr >> c_BYTE_W);
    endfunction

    // Callers truncate the index/tag to the width implied by their line count.
    function automatic logic [c_MAX_INDEX_W-1:0] addr_index(input logic [31:0] addr,
                                                            input int index_w);
        return c_MAX_INDEX_W'((addr >> c_LINE_LSB) & ((32'd1 << index_w) - 32'd1));
    endfunction

    function automatic logic [c_MAX_TAG_W-1:0] addr_tag(input logic [31:0] addr,
                                                        input int index_w);
        return c_MAX_TAG_W'(addr >> (c_LINE_LSB + index_w));
    endfunction

endpackage
`default_nettype wire

// File: rtl/data_cache_array.sv
`default_nettype none
// ============================================================================
// Module      : cache_array
// Description : Valid/tag/data storage, one synchronous write port and an
//               asynchronous read port.
// Revision    : 1.0 - initial release
// ============================================================================
module cache_array
    import data_cache_pkg::*;
#(
    parameter int NUM_LINES = 16,
    parameter int WORDS     = c_WORDS_PER_LINE
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic [$clog2(NUM_LINES)-1:0]             i_rd_index,
    input  logic [c_OFFSET_W-1:0]                    i_rd_offset,
    output logic                                     o_rd_valid,
    output logic [32-c_LINE_LSB-$clog2(NUM_LINES)-1:0] o_rd_tag,
    output logic [31:0]                              o_rd_word,
    input  logic                                     i_wr_en,
    input  logic [$clog2(NUM_LINES)-1:0]             i_wr_index,
    input  logic [c_OFFSET_W-1:0]                    i_wr_offset,
    input  logic [31:0]                              i_wr_word,
    input  logic                                     i_wr_meta,
    input  logic                                     i_wr_valid,
    input  logic [32-c_LINE_LSB-$clog2(NUM_LINES)-1:0] i_wr_tag
);

    localparam int c_TAG_W = 32 - c_LINE_LSB - $clog2(NUM_LINES);

    logic [NUM_LINES-1:0] r_valid;
    logic [c_TAG_W-1:0]   r_tag  [NUM_LINES];
    logic [31:0]          r_data [NUM_LINES][WORDS];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
        end else if (i_wr_en && i_wr_meta) begin
            r_valid[i_wr_index] <= i_wr_valid;
        end
    end

    // Tag and data need no reset: a line is only trusted once its valid bit is set.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_data[i_wr_index][i_wr_offset] <= i_wr_word;
            if (i_wr_meta) begin
                r_tag[i_wr_index] <= i_wr_tag;
            end
        end
    end

    assign o_rd_valid = r_valid[i_rd_index];
    assign o_rd_tag   = r_tag[i_rd_index];
    assign o_rd_word  = r_data[i_rd_index][i_rd_offset];

endmodule
`default_nettype wire

// File: rtl/data_cache.sv
`default_nettype none
// ============================================================================
// Module      : data_cache
// Description : Direct-mapped, write-through, read-allocate data cache with a
//               one-word-per-ack memory port. Optional hit/miss statistics
//               counters are enabled by defining DATA_CACHE_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module data_cache
    import data_cache_pkg::*;
#(
    parameter int NUM_LINES      = 16,
    parameter int WORDS_PER_LINE = c_WORDS_PER_LINE
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    output logic [31:0] data_o,
    output logic        stall_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic        mem_rd_o,
    output logic        mem_wr_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_ack_i
`ifdef DATA_CACHE_STATS_EN
    ,
    output logic [31:0] hit_cnt_o,
    output logic [31:0] miss_cnt_o
`endif
);

    localparam int c_INDEX_W = $clog2(NUM_LINES);
    localparam int c_TAG_W   = 32 - c_LINE_LSB - c_INDEX_W;

    logic [c_OFFSET_W-1:0] w_offset;
    logic [c_INDEX_W-1:0]  w_index;
    logic [c_TAG_W-1:0]    w_tag;

    assign w_offset = addr_offset(addr_i);
    assign w_index  = c_INDEX_W'(addr_index(addr_i, c_INDEX_W));
    assign w_tag    = c_TAG_W'(addr_tag(addr_i, c_INDEX_W));

    state_t                r_state;
    state_t                w_next;
    logic [c_OFFSET_W-1:0] r_cnt;

    logic                  w_rd_valid;
    logic [c_TAG_W-1:0]    w_rd_tag;
    logic [31:0]           w_rd_word;
    logic                  w_hit;
    logic                  w_wr_en;
    logic                  w_wr_meta;
    logic                  w_wr_valid;
    logic [c_OFFSET_W-1:0] w_wr_offset;
    logic [31:0]           w_wr_word;

    assign w_hit = w_rd_valid && (w_rd_tag == w_tag);

    cache_array #(
        .NUM_LINES (NUM_LINES),
        .WORDS     (WORDS_PER_LINE)
    ) u_array (
        .clk         (clk_i),
        .rst         (rst_i),
        .i_rd_index  (w_index),
        .i_rd_offset (w_offset),
        .o_rd_valid  (w_rd_valid),
        .o_rd_tag    (w_rd_tag),
        .o_rd_word   (w_rd_word),
        .i_wr_en     (w_wr_en),
        .i_wr_index  (w_index),
        .i_wr_offset (w_wr_offset),
        .i_wr_word   (w_wr_word),
        .i_wr_meta   (w_wr_meta),
        .i_wr_valid  (w_wr_valid),
        .i_wr_tag    (w_tag)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == FILL && mem_ack_i) begin
                r_cnt <= r_cnt + 2'd1;
            end
        end
    end

    always_comb begin
        w_next      = r_state;
        stall_o     = 1'b0;
        data_o      = '0;
        mem_rd_o    = 1'b0;
        mem_wr_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        w_wr_en     = 1'b0;
        w_wr_meta   = 1'b0;
        w_wr_valid  = 1'b0;
        w_wr_offset = w_offset;
        w_wr_word   = data_i;
        case (r_state)
            IDLE: begin
                if (MemWrite_i) begin
                    stall_o = 1'b1;
                    w_next  = WRITE;
                end else if (MemRead_i) begin
                    if (w_hit) begin
                        data_o = w_rd_word;
                    end else begin
                        stall_o = 1'b1;
                        w_next  = FILL;
                    end
                end
            end
            FILL: begin
                stall_o    = 1'b1;
                mem_rd_o   = 1'b1;
                mem_addr_o = {w_tag, w_index, r_cnt, 2'b00};
                if (mem_ack_i) begin
                    w_wr_en     = 1'b1;
                    w_wr_offset = r_cnt;
                    w_wr_word   = mem_rdata_i;
                    // Drop the old line on the first word so a partial fill never hits.
                    if (r_cnt == 2'd0) begin
                        w_wr_meta = 1'b1;
                    end
                    if (r_cnt == 2'd3) begin
                        w_wr_meta  = 1'b1;
                        w_wr_valid = 1'b1;
                        w_next     = DONE;
                    end
                end
            end
            WRITE: begin
                stall_o     = 1'b1;
                mem_wr_o    = 1'b1;
                mem_addr_o  = {addr_i[31:2], 2'b00};
                mem_wdata_o = data_i;
                if (mem_ack_i) begin
                    w_wr_en = w_hit;
                    w_next  = DONE;
                end
            end
            DONE: begin
                if (w_hit) begin
                    data_o = w_rd_word;
                end
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

`ifdef DATA_CACHE_STATS_EN
    logic [31:0] r_hit_cnt;
    logic [31:0] r_miss_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else if (r_state == IDLE && MemRead_i && !MemWrite_i) begin
            if (w_hit) begin
                if (r_hit_cnt != 32'hFFFF_FFFF) r_hit_cnt <= r_hit_cnt + 32'd1;
            end else begin
                if (r_miss_cnt != 32'hFFFF_FFFF) r_miss_cnt <= r_miss_cnt + 32'd1;
            end
        end
    end

    assign hit_cnt_o  = r_hit_cnt;
    assign miss_cnt_o = r_miss_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_data_cache.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_cache
// Description : Scoreboard bench for data_cache: directed scenarios followed
//               by random loads/stores against a line-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_cache;

    localparam int NUM_LINES = 16;
    localparam int TIMEOUT   = 400;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [31:0] addr_i;
    logic [31:0] data_i;
    logic        MemRead_i;
    logic        MemWrite_i;
    logic [31:0] data_o;
    logic        stall_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_rd_o;
    logic        mem_wr_o;
    logic [31:0] mem_rdata_i = '0;
    logic        mem_ack_i   = 1'b0;
`ifdef DATA_CACHE_STATS_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;
`endif

    always #5 clk = ~clk;

    data_cache #(.NUM_LINES(NUM_LINES)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .addr_i      (addr_i),
        .data_i      (data_i),
        .MemRead_i   (MemRead_i),
        .MemWrite_i  (MemWrite_i),
        .data_o      (data_o),
        .stall_o     (stall_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_rd_o    (mem_rd_o),
        .mem_wr_o    (mem_wr_o),
        .mem_rdata_i (mem_rdata_i),
        .mem_ack_i   (mem_ack_i)
`ifdef DATA_CACHE_STATS_EN
        ,
        .hit_cnt_o   (hit_cnt),
        .miss_cnt_o  (miss_cnt)
`endif
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] data;
        int          fills;
        logic [31:0] base;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wexp_t;

    exp_t        exp_q [$];
    wexp_t       wexp_q[$];
    logic [31:0] phys_mem[bit [29:0]];
    logic [31:0] ref_mem [bit [29:0]];
    logic [27:0] line_of [int];
    int          fixed_delay = 2;

    function automatic logic [31:0] init_word(input bit [29:0] w);
        return ({2'b00, w} * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] phys_read(input bit [29:0] w);
        return phys_mem.exists(w) ? phys_mem[w] : init_word(w);
    endfunction

    function automatic logic [31:0] ref_read(input bit [29:0] w);
        return ref_mem.exists(w) ? ref_mem[w] : init_word(w);
    endfunction

    function automatic void check32(input string name, input logic [31:0] act,
                                    input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s: got event expected none at %0t", name, $time);
    endfunction

    task automatic finish_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    endtask

    // Memory: acks one word after a configurable number of wait cycles.
    int wait_cnt  = 0;
    int cur_delay = 0;
    always @(posedge clk) begin
        #2;
        if (rst_i || mem_ack_i) begin
            mem_ack_i = 1'b0;
            wait_cnt  = 0;
        end else if (mem_rd_o || mem_wr_o) begin
            if (wait_cnt == 0) begin
                cur_delay = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 3));
            end
            if (wait_cnt >= cur_delay) begin
                mem_ack_i = 1'b1;
                if (mem_wr_o) phys_mem[mem_addr_o[31:2]] = mem_wdata_o;
                else          mem_rdata_i = phys_read(mem_addr_o[31:2]);
            end else begin
                wait_cnt++;
            end
        end else begin
            wait_cnt = 0;
        end
    end

    // Monitor: pops expectations whenever the DUT completes a transfer or a load.
    int fill_seen = 0;
    always @(negedge clk) begin : mon
        exp_t  e;
        wexp_t w;
        if (rst_i) begin
            fill_seen = 0;
        end else begin
            if (mem_rd_o || mem_wr_o) check32("rd_wr_exclusive", {31'd0, mem_rd_o && mem_wr_o}, 32'd0);
            if (mem_ack_i && mem_rd_o) begin
                if (exp_q.size() > 0) check32("fill_addr", mem_addr_o, exp_q[0].base + 32'(4 * fill_seen));
                fill_seen++;
            end
            if (mem_ack_i && mem_wr_o) begin
                if (wexp_q.size() == 0) begin
                    fail_now("store_unexpected");
                end else begin
                    w = wexp_q.pop_front();
                    check32("store_addr", mem_addr_o, w.addr);
                    check32("store_data", mem_wdata_o, w.data);
                end
            end
            if (MemRead_i && !MemWrite_i && !stall_o) begin
                if (exp_q.size() == 0) begin
                    fail_now("load_unexpected");
                end else begin
                    e = exp_q.pop_front();
                    check32("load_data", data_o, e.data);
                    check32("fill_words", 32'(fill_seen), 32'(e.fills));
                end
                fill_seen = 0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cycle_req(input logic rd, input logic wr, input logic [31:0] a,
                             input logic [31:0] d, output int stalls);
        addr_i     = a;
        data_i     = d;
        MemRead_i  = rd;
        MemWrite_i = wr;
        stalls     = 0;
        for (int n = 0; n < TIMEOUT; n++) begin
            @(negedge clk);
            if (!stall_o) break;
            stalls++;
        end
        if (stalls >= TIMEOUT) begin
            fail_now("request_timeout");
            finish_run();
        end
        step();
        MemRead_i  = 1'b0;
        MemWrite_i = 1'b0;
    endtask

    task automatic do_load(input logic [31:0] a, output int stalls);
        exp_t e;
        int   idx;
        bit   hit;
        idx     = int'((a >> 4) % NUM_LINES);
        hit     = line_of.exists(idx) && (line_of[idx] == a[31:4]);
        e.data  = ref_read(a[31:2]);
        e.fills = hit ? 0 : 4;
        e.base  = {a[31:4], 4'h0};
        exp_q.push_back(e);
        line_of[idx] = a[31:4];
        cycle_req(1'b1, 1'b0, a, $urandom, stalls);
    endtask

    task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic also_rd);
        wexp_t w;
        int    stalls;
        w.addr = {a[31:2], 2'b00};
        w.data = d;
        wexp_q.push_back(w);
        ref_mem[a[31:2]] = d;
        cycle_req(also_rd, 1'b1, a, d, stalls);
    endtask

    task automatic do_reset();
        rst_i      = 1'b1;
        MemRead_i  = 1'b0;
        MemWrite_i = 1'b0;
        step();
        step();
        rst_i = 1'b0;
        line_of.delete();
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int st;
        int acks;
        logic [31:0] a;
        int r;
        rst_i = 1'b1; MemRead_i = 1'b0; MemWrite_i = 1'b0; addr_i = '0; data_i = '0;
        step();
        do_reset();

        @(negedge clk);
        check32("reset_stall", {31'd0, stall_o}, 32'd0);
        check32("reset_mem_rd", {31'd0, mem_rd_o}, 32'd0);
        check32("reset_mem_wr", {31'd0, mem_wr_o}, 32'd0);
        check32("reset_data", data_o, 32'd0);
        step();

        do_load(32'h40, st);
        check32("miss_stall_cycles_ge8", {31'd0, st >= 8}, 32'd1);
        do_load(32'h44, st);
        check32("hit_stall_cycles", 32'(st), 32'd0);
        do_store(32'h48, 32'hDEAD_BEEF, 1'b0);
        do_load(32'h48, st);
        do_store(32'h1000, 32'h1234_5678, 1'b0);
        do_load(32'h40, st);
        do_load(32'h1000, st);

        // Reset in the middle of a line fill.
        addr_i = 32'h2000; MemRead_i = 1'b1; MemWrite_i = 1'b0;
        acks = 0;
        for (int n = 0; n < TIMEOUT && acks < 2; n++) begin
            @(negedge clk);
            if (mem_ack_i && mem_rd_o) acks++;
        end
        check32("midfill_acks", 32'(acks), 32'd2);
        step();
        rst_i = 1'b1; MemRead_i = 1'b0;
        step();
        rst_i = 1'b0;
        line_of.delete();
        @(negedge clk);
        check32("abort_mem_rd", {31'd0, mem_rd_o}, 32'd0);
        check32("abort_stall", {31'd0, stall_o}, 32'd0);
        step();
        do_load(32'h2000, st);

        // Conflict eviction on a shared index.
        do_reset();
        do_load(32'h40, st);
        do_load(32'h440, st);
        do_load(32'h40, st);
`ifdef DATA_CACHE_STATS_EN
        @(negedge clk);
        check32("stats_miss", miss_cnt, 32'd3);
        check32("stats_hit", hit_cnt, 32'd0);
        step();
`endif

        fixed_delay = -1;
        for (int i = 0; i < 400; i++) begin
            a = ($urandom_range(0, 255) << 2) | $urandom_range(0, 3);
            r = int'($urandom_range(0, 9));
            if (r < 6)      do_load(a, st);
            else if (r < 9) do_store(a, $urandom, 1'b0);
            else            do_store(a, $urandom, 1'b1);
            if ($urandom_range(0, 3) == 0) step();
        end

        repeat (3) step();
        check32("load_queue_drained", 32'(exp_q.size()), 32'd0);
        check32("store_queue_drained", 32'(wexp_q.size()), 32'd0);
        finish_run();
    end

endmodule
`default_nettype wire
